// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared integer register-file constants for decode, issue and writeback
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - read, write and allocation bundle of the multi-port register file
interface multiport_regfile_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write tracker used for RAW hazard detection
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   busy_vec
);
    import riscv_pkg::*;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Alloc is applied after writes so a new producer wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - parametrised multi-port integer register file with write bypass and scoreboard
module multiport_regfile #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multiport_regfile_if.slave   rf
);
    import riscv_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy_q;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (rf.alloc_en),
        .alloc_addr (rf.alloc_addr),
        .wr_en      (rf.wr_en),
        .wr_addr    (rf.wr_addr),
        .busy_vec   (busy_q)
    );

    assign rf.busy_vec = busy_q;

    // Later ports are scheduled last, so the highest index wins a same-address conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] != ZERO_ADDR) begin
                    mem[rf.wr_addr[j*AW +: AW]] <= rf.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rf.rd_addr[i*AW +: AW];

        // Bypassed data is already available, so a same-cycle write clears the hazard.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr != ZERO_ADDR) begin
                data = mem[addr];
                busy = busy_q[addr];
                for (int j = 0; j < NWR; j++) begin
                    if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] == addr) begin
                        data = rf.wr_data[j*XLEN +: XLEN];
                        busy = 1'b0;
                    end
                end
            end
        end

        assign rf.rd_data[i*XLEN +: XLEN] = data;
        assign rf.rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed self-checking bench for multiport_regfile
module tb_multiport_regfile;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multiport_regfile_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) rf ();
    multiport_regfile_if #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) sw ();

    multiport_regfile #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf.slave)
    );

    multiport_regfile #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) dut_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.wr_en      = '0;
        rf.alloc_en   = 1'b0;
        sw.wr_en      = '0;
        sw.alloc_en   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        rf.rd_addr = '0; rf.wr_en = '0; rf.wr_addr = '0; rf.wr_data = '0;
        rf.alloc_en = 1'b0; rf.alloc_addr = '0;
        sw.rd_addr = '0; sw.wr_en = '0; sw.wr_addr = '0; sw.wr_data = '0;
        sw.alloc_en = 1'b0; sw.alloc_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy_vec", 64'(rf.busy_vec), 64'h0);
        chk("reset_rd_data0", 64'(rf.rd_data[31:0]), 64'h0);
        #8 rst_n = 1'b1;

        // write r5 and allocate r4 together, then reset mid-cycle
        tick();
        rf.wr_en = 2'b01;
        rf.wr_addr[0 +: 5] = 5'd5;
        rf.wr_data[0 +: 32] = 32'hDEADBEEF;
        rf.alloc_en = 1'b1;
        rf.alloc_addr = 5'd4;
        tick();
        idle();
        rf.rd_addr[0 +: 5] = 5'd5;
        #1;
        chk("r5_stored", 64'(rf.rd_data[0 +: 32]), 64'hDEADBEEF);
        chk("r4_busy", 64'(rf.busy_vec), 64'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_r5", 64'(rf.rd_data[0 +: 32]), 64'h0);
        chk("async_reset_busy_vec", 64'(rf.busy_vec), 64'h0);
        #1 rst_n = 1'b1;

        // bypass on read port 1 against a pending r7
        tick();
        rf.alloc_en = 1'b1;
        rf.alloc_addr = 5'd7;
        rf.rd_addr[5 +: 5] = 5'd7;
        tick();
        idle();
        #1;
        chk("r7_busy_before_write", 64'(rf.rd_busy[1]), 64'h1);
        rf.wr_en = 2'b01;
        rf.wr_addr[0 +: 5] = 5'd7;
        rf.wr_data[0 +: 32] = 32'h12345678;
        #1;
        chk("bypass_data", 64'(rf.rd_data[32 +: 32]), 64'h12345678);
        chk("bypass_busy", 64'(rf.rd_busy[1]), 64'h0);
        tick();
        idle();
        #1;
        chk("r7_stored", 64'(rf.rd_data[32 +: 32]), 64'h12345678);
        chk("r7_busy_cleared", 64'(rf.busy_vec), 64'h0);

        // write-port priority on r3
        rf.wr_en = 2'b11;
        rf.wr_addr = {5'd3, 5'd3};
        rf.wr_data = {32'h22, 32'h11};
        rf.rd_addr[0 +: 5] = 5'd3;
        #1;
        chk("prio_bypass", 64'(rf.rd_data[0 +: 32]), 64'h22);
        tick();
        idle();
        #1;
        chk("prio_stored", 64'(rf.rd_data[0 +: 32]), 64'h22);

        // scoreboard on r9
        rf.alloc_en = 1'b1;
        rf.alloc_addr = 5'd9;
        rf.rd_addr[0 +: 5] = 5'd9;
        #1;
        chk("alloc_not_same_cycle", 64'(rf.rd_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("alloc_busy_vec", 64'(rf.busy_vec), 64'h200);
        chk("alloc_rd_busy", 64'(rf.rd_busy[0]), 64'h1);
        rf.wr_en = 2'b10;
        rf.wr_addr[5 +: 5] = 5'd9;
        rf.wr_data[32 +: 32] = 32'hA5;
        #1;
        chk("write_clears_rd_busy", 64'(rf.rd_busy[0]), 64'h0);
        chk("write_bypass_r9", 64'(rf.rd_data[0 +: 32]), 64'hA5);
        tick();
        idle();
        #1;
        chk("write_clears_busy_vec", 64'(rf.busy_vec), 64'h0);
        rf.alloc_en = 1'b1;
        rf.alloc_addr = 5'd9;
        rf.wr_en = 2'b01;
        rf.wr_addr[0 +: 5] = 5'd9;
        rf.wr_data[0 +: 32] = 32'h5A;
        tick();
        idle();
        #1;
        chk("alloc_write_busy", 64'(rf.busy_vec), 64'h200);
        chk("alloc_write_data", 64'(rf.rd_data[0 +: 32]), 64'h5A);
        rf.alloc_en = 1'b1;
        tick();
        idle();
        #1;
        chk("waw_realloc_busy", 64'(rf.busy_vec), 64'h200);

        // zero register
        rf.wr_en = 2'b01;
        rf.wr_addr[0 +: 5] = 5'd0;
        rf.wr_data[0 +: 32] = 32'hFFFFFFFF;
        rf.alloc_en = 1'b1;
        rf.alloc_addr = 5'd0;
        rf.rd_addr[0 +: 5] = 5'd0;
        #1;
        chk("r0_no_bypass", 64'(rf.rd_data[0 +: 32]), 64'h0);
        tick();
        idle();
        #1;
        chk("r0_stored", 64'(rf.rd_data[0 +: 32]), 64'h0);
        chk("r0_rd_busy", 64'(rf.rd_busy[0]), 64'h0);
        chk("r0_busy_vec", 64'(rf.busy_vec), 64'h200);

        // write to a non-busy register
        rf.wr_en = 2'b10;
        rf.wr_addr[5 +: 5] = 5'd11;
        rf.wr_data[32 +: 32] = 32'h77;
        rf.rd_addr[5 +: 5] = 5'd11;
        tick();
        idle();
        #1;
        chk("nonbusy_write_data", 64'(rf.rd_data[32 +: 32]), 64'h77);
        chk("nonbusy_write_busy", 64'(rf.busy_vec), 64'h200);

        // parameter sweep instance
        sw.wr_en = 1'b1;
        sw.wr_addr = 4'd15;
        sw.wr_data = 64'h0123456789ABCDEF;
        sw.rd_addr = {4'd15, 4'd15, 4'd15};
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sweep_bypass%0d", i), sw.rd_data[i*64 +: 64], 64'h0123456789ABCDEF);
        end
        tick();
        idle();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sweep_stored%0d", i), sw.rd_data[i*64 +: 64], 64'h0123456789ABCDEF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised successor to the single-write, two-read integer register file. It provides configurable width, depth, and read/write port counts. It adds same-cycle write-to-read bypass and an asynchronous clear. A per-register scoreboard tracks outstanding writes so the issue stage can detect RAW hazards. It sits between decode/issue (reads, allocation) and writeback (writes) in the multi-issue pipeline.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREG), register address width (derived; not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rd_addr  input  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  output  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rd_busy  output  NRD  1 = addressed register has a pending write
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*AW  write addresses
- wr_data  input  NWR*XLEN  write data
- alloc_en  input  1  issue stage reserves a destination register
- alloc_addr  input  AW  register being reserved
- busy_vec  output  NREG  full scoreboard, bit r = register r pending

## Operation
- Register 0 is hardwired to zero.
  - Writes to r0 are dropped.
  - alloc to r0 is ignored.
  - Reads of r0 return 0 with rd_busy 0.
  - busy_vec[0] is always 0.
- Reads are combinational, with write-first bypass.
  - If any wr_en[j] targets rd_addr[i] (nonzero) in the current cycle, rd_data[i] returns that wr_data.
  - Otherwise rd_data[i] returns the stored value.
- Write conflicts: if several write ports target the same nonzero address in one cycle, the highest port index wins. This applies to both storage and bypass.
- Scoreboard, evaluated per register r at each rising edge:
  - Set if alloc_en and alloc_addr == r.
  - Else clear if any wr_en[j] and wr_addr[j] == r.
  - Else hold.
  - Simultaneous alloc and write to the same r: the write updates data, and busy ends at 1 (the new producer is pending).
- Re-allocating an already-busy register (WAW) is legal; busy stays 1.
- rd_busy[i] reflects the registered busy bit as modified by same-cycle writes.
  - A write to that register this cycle makes rd_busy[i] = 0, because the data is bypassed.
  - A same-cycle alloc is not reflected until the next cycle.
- Writing a register that is not busy is legal; data updates and busy stays 0.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Writes and allocs take effect at the rising clk edge.
  - A read in the following cycle sees the stored value.
  - busy_vec shows an allocation one cycle after alloc_en.
- Reset, asserted asynchronously (at any time, including mid-write):
  - All registers clear to 0.
  - All busy bits clear to 0.
  - Outputs immediately become rd_data = 0 (absent bypass), rd_busy = 0, busy_vec = 0.
- Reset release is synchronised externally. Writes and allocs in the first edge after deassertion are honoured.
- No handshake back-pressure: every wr_en/alloc_en is accepted in the cycle it is asserted.

## Structure
- Shared package riscv_pkg holds XLEN, NREG, and the REG_ZERO constant, common with decode and writeback.
- One sub-module, regfile_scoreboard, is natural.
  - Ports: clk, rst_n, alloc_en/addr, wr_en/addr vectors.
  - Output: busy_vec.
  - multiport_regfile instantiates it and adds storage, the write-priority mux, and bypass.

## Test plan
- Reset then read: assert rst_n = 0 mid-run after writing r5 = 0xDEADBEEF, then read r5 -> 0, busy_vec = 0, before any clk edge.
- Bypass: wr_en[0], r7 = 0x12345678, with rd_addr[1] = 7 in the same cycle -> rd_data[1] = 0x12345678 combinationally, rd_busy[1] = 0. Next cycle, with no write, reads 0x12345678.
- Port priority: wr port 0 writes r3 = 0x11 and port 1 writes r3 = 0x22 in the same cycle -> bypass 0x22; stored value 0x22.
- Scoreboard: alloc r9 -> busy_vec[9] = 1 next cycle. Write r9 = 0xA5 -> busy_vec[9] = 0 next cycle. Alloc and write r9 in the same cycle -> busy_vec[9] = 1, data = written value.
- Zero register: write r0 = 0xFFFFFFFF and alloc r0 -> read r0 = 0, busy_vec[0] = 0.
- Parameter sweep: NREG = 16, NRD = 3, NWR = 1, XLEN = 64. Write r15 = 0x0123456789ABCDEF and read it on all three ports -> all return that value.
